// File: rtl/deser_pkg.sv
// Shared types and helpers for the serial-to-parallel deserializer.
package deser_pkg;

    typedef enum logic {COLLECT, HOLD} deser_state_t;

    localparam int DEFAULT_WIDTH = 8;

    // Maps a pointer count to its physical lane, honouring bit order.
    function automatic int lane_of(input int ptr, input bit msb_first, input int width = DEFAULT_WIDTH);
        return msb_first ? (width - 1 - ptr) : ptr;
    endfunction

endpackage

// File: rtl/dmux_onehot.sv
// Pointer-to-one-hot lane write decoder, gated by the accept strobe.
module dmux_onehot
    import deser_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic [$clog2(WIDTH)-1:0] ptr,
    input  logic                     strobe,
    output logic [WIDTH-1:0]         we
);

    always_comb begin
        we = '0;
        for (int i = 0; i < WIDTH; i++) begin
            we[i] = strobe && (lane_of(int'(ptr), MSB_FIRST, WIDTH) == i);
        end
    end

endmodule

// File: rtl/deser8_way.sv
// Serial-to-parallel deserializer with an assembly register and a
// double-buffered output holding register, valid/ready on both sides.
module deser8_way
    import deser_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             frame_start,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overrun,
    input  logic             clear_err
);

    localparam int PW = $clog2(WIDTH);
    localparam logic [PW-1:0] LAST = PW'(WIDTH - 1);

    deser_state_t     state, state_next;
    logic [PW-1:0]    ptr, ptr_next, lane_ptr;
    logic [WIDTH-1:0] asm_word, asm_next, out_next, lane_we, word;
    logic             out_valid_next, overrun_next;
    logic             accept, sync, complete, out_free;

    assign in_ready = (state == COLLECT);
    assign accept   = in_valid && in_ready;
    assign sync     = accept && frame_start;
    assign lane_ptr = sync ? '0 : ptr;
    assign complete = accept && (lane_ptr == LAST);
    assign out_free = !out_valid || out_ready;

    // A resync discards the partial word, so the merge base becomes zero.
    assign word = ((sync ? '0 : asm_word) & ~lane_we) | (lane_we & {WIDTH{in}});

    dmux_onehot #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_dmux (
        .ptr    (lane_ptr),
        .strobe (accept),
        .we     (lane_we)
    );

    always_comb begin
        state_next     = state;
        ptr_next       = ptr;
        asm_next       = asm_word;
        out_next       = out;
        out_valid_next = out_valid && !out_ready;
        overrun_next   = (overrun && !clear_err) || (sync && (ptr != '0));
        case (state)
            COLLECT: begin
                if (accept) begin
                    if (complete) begin
                        ptr_next = '0;
                        if (out_free) begin
                            out_next       = word;
                            out_valid_next = 1'b1;
                            asm_next       = '0;
                        end else begin
                            asm_next   = word;
                            state_next = HOLD;
                        end
                    end else begin
                        asm_next = word;
                        ptr_next = lane_ptr + PW'(1);
                    end
                end
            end
            HOLD: begin
                if (out_free) begin
                    out_next       = asm_word;
                    out_valid_next = 1'b1;
                    asm_next       = '0;
                    ptr_next       = '0;
                    state_next     = COLLECT;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= COLLECT;
            ptr       <= '0;
            asm_word  <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_next;
            ptr       <= ptr_next;
            asm_word  <= asm_next;
            out       <= out_next;
            out_valid <= out_valid_next;
            overrun   <= overrun_next;
        end
    end

endmodule

// File: tb/tb_deser8_way.sv
// Scenario bench for deser8_way: LSB-first and MSB-first instances share stimulus.
module tb_deser8_way;
    import deser_pkg::*;

    logic       clk = 1'b0;
    logic       reset, in, in_valid, frame_start, out_ready, clear_err;
    logic [7:0] out, out_msb;
    logic       in_ready, out_valid, overrun;
    logic       in_ready_msb, out_valid_msb, overrun_msb;

    int         pass_cnt = 0;
    int         total_cnt = 0;
    logic [7:0] sb[$];
    logic [7:0] sb_exp;

    always #5 clk = ~clk;

    deser8_way #(.WIDTH(8), .MSB_FIRST(1'b0)) dut (
        .clk(clk), .reset(reset), .in(in), .in_valid(in_valid), .in_ready(in_ready),
        .frame_start(frame_start), .out(out), .out_valid(out_valid), .out_ready(out_ready),
        .overrun(overrun), .clear_err(clear_err)
    );

    deser8_way #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .reset(reset), .in(in), .in_valid(in_valid), .in_ready(in_ready_msb),
        .frame_start(frame_start), .out(out_msb), .out_valid(out_valid_msb), .out_ready(out_ready),
        .overrun(overrun_msb), .clear_err(clear_err)
    );

    // Scoreboard: every word the consumer takes must match the oldest expected word.
    always @(negedge clk) begin
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            total_cnt++;
            if (sb.size() == 0) begin
                $display("FAIL sb_take: got word %h, expected queue empty", out);
            end else begin
                sb_exp = sb.pop_front();
                if (out !== sb_exp) $display("FAIL sb_take: got %h expected %h", out, sb_exp);
                else pass_cnt++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_bit(input logic b, input logic fs);
        in = b; in_valid = 1'b1; frame_start = fs;
        @(posedge clk); #1;
        in_valid = 1'b0; frame_start = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; in = 1'b0; in_valid = 1'b0; frame_start = 1'b0;
        out_ready = 1'b0; clear_err = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        total_cnt++; if (out !== 8'h00) $display("FAIL reset_out: got %h expected 00", out); else pass_cnt++;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready); else pass_cnt++;
        total_cnt++; if (overrun !== 1'b0) $display("FAIL reset_overrun: got %b expected 0", overrun); else pass_cnt++;
    endtask

    task automatic test_basic;
        logic [7:0] pat;
        logic early;
        pat = 8'h4D;
        early = 1'b0;
        out_ready = 1'b1;
        sb.push_back(8'h4D);
        for (int i = 0; i < 8; i++) begin
            send_bit(pat[i], i == 0);
            if (i < 7 && out_valid !== 1'b0) early = 1'b1;
        end
        total_cnt++; if (early) $display("FAIL basic_early_valid: got 1 expected 0 before last bit"); else pass_cnt++;
        total_cnt++; if (out_valid !== 1'b1 || out !== 8'h4D)
            $display("FAIL basic_word: got valid=%b out=%h expected valid=1 out=4d", out_valid, out); else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL basic_one_cycle: got %b expected 0", out_valid); else pass_cnt++;
    endtask

    task automatic test_msb_first;
        logic [7:0] pat;
        pat = 8'h4D;
        out_ready = 1'b1;
        sb.push_back(8'h4D);
        for (int i = 0; i < 8; i++) send_bit(pat[i], i == 0);
        total_cnt++; if (out_valid_msb !== 1'b1 || out_msb !== 8'hB2)
            $display("FAIL msb_word: got valid=%b out=%h expected valid=1 out=b2", out_valid_msb, out_msb); else pass_cnt++;
        @(posedge clk); #1;
    endtask

    task automatic test_back_pressure;
        logic [15:0] pat;
        logic stable;
        pat = 16'h0FFF;
        stable = 1'b1;
        out_ready = 1'b0;
        sb.push_back(8'hFF);
        sb.push_back(8'h0F);
        for (int i = 0; i < 16; i++) begin
            send_bit(pat[i], i == 0 || i == 8);
            if (i == 7) begin
                total_cnt++; if (out_valid !== 1'b1 || out !== 8'hFF)
                    $display("FAIL bp_first: got valid=%b out=%h expected valid=1 out=ff", out_valid, out); else pass_cnt++;
            end
            if (i > 7 && (out_valid !== 1'b1 || out !== 8'hFF)) stable = 1'b0;
        end
        total_cnt++; if (!stable) $display("FAIL bp_stable: got out=%h expected ff held", out); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready: got %b expected 0", in_ready); else pass_cnt++;
        total_cnt++; if (dut.state !== HOLD) $display("FAIL bp_state: got %0d expected HOLD", dut.state); else pass_cnt++;
        // frame_start while stalled must be ignored
        send_bit(1'b1, 1'b1);
        total_cnt++; if (overrun !== 1'b0) $display("FAIL bp_ignored_fs: got overrun=%b expected 0", overrun); else pass_cnt++;
        out_ready = 1'b1;
        @(posedge clk); #1;
        total_cnt++; if (out_valid !== 1'b1 || out !== 8'h0F)
            $display("FAIL bp_second: got valid=%b out=%h expected valid=1 out=0f", out_valid, out); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL bp_ready_back: got %b expected 1", in_ready); else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL bp_drain: got %b expected 0", out_valid); else pass_cnt++;
    endtask

    task automatic test_resync;
        out_ready = 1'b1;
        total_cnt++; if (overrun !== 1'b0) $display("FAIL rs_initial: got %b expected 0", overrun); else pass_cnt++;
        sb.push_back(8'h01);
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b1);
        total_cnt++; if (overrun !== 1'b1) $display("FAIL rs_overrun: got %b expected 1", overrun); else pass_cnt++;
        total_cnt++; if (dut.ptr !== 3'd1) $display("FAIL rs_ptr: got %0d expected 1", dut.ptr); else pass_cnt++;
        for (int i = 0; i < 7; i++) send_bit(1'b0, 1'b0);
        total_cnt++; if (out_valid !== 1'b1 || out !== 8'h01)
            $display("FAIL rs_word: got valid=%b out=%h expected valid=1 out=01", out_valid, out); else pass_cnt++;
        total_cnt++; if (overrun !== 1'b1) $display("FAIL rs_sticky: got %b expected 1", overrun); else pass_cnt++;
        clear_err = 1'b1;
        @(posedge clk); #1;
        clear_err = 1'b0;
        total_cnt++; if (overrun !== 1'b0) $display("FAIL rs_clear: got %b expected 0", overrun); else pass_cnt++;
        // set and clear in the same cycle: set wins
        send_bit(1'b0, 1'b1);
        send_bit(1'b0, 1'b0);
        sb.push_back(8'hFE);
        clear_err = 1'b1;
        send_bit(1'b0, 1'b1);
        clear_err = 1'b0;
        total_cnt++; if (overrun !== 1'b1) $display("FAIL rs_set_wins: got %b expected 1", overrun); else pass_cnt++;
        for (int i = 0; i < 7; i++) send_bit(1'b1, 1'b0);
        clear_err = 1'b1;
        @(posedge clk); #1;
        clear_err = 1'b0;
        total_cnt++; if (overrun !== 1'b0) $display("FAIL rs_clear2: got %b expected 0", overrun); else pass_cnt++;
    endtask

    task automatic test_reset_hold;
        logic [15:0] junk;
        logic [7:0] pat;
        junk = 16'h5AC3;
        pat = 8'hA5;
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) send_bit(junk[i], i == 0);
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL rh_in_hold: got in_ready=%b expected 0", in_ready); else pass_cnt++;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        total_cnt++; if (out_valid !== 1'b0 || out !== 8'h00)
            $display("FAIL rh_out: got valid=%b out=%h expected valid=0 out=00", out_valid, out); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL rh_in_ready: got %b expected 1", in_ready); else pass_cnt++;
        total_cnt++; if (dut.ptr !== 3'd0 || dut.asm_word !== 8'h00)
            $display("FAIL rh_state: got ptr=%0d asm=%h expected 0 and 00", dut.ptr, dut.asm_word); else pass_cnt++;
        out_ready = 1'b1;
        sb.push_back(8'hA5);
        for (int i = 0; i < 8; i++) send_bit(pat[i], 1'b0);
        total_cnt++; if (out_valid !== 1'b1 || out !== 8'hA5)
            $display("FAIL rh_fresh: got valid=%b out=%h expected valid=1 out=a5", out_valid, out); else pass_cnt++;
        @(posedge clk); #1;
    endtask

    task automatic test_stall_gaps;
        logic [7:0] pat;
        logic [2:0] ptr_before;
        logic [7:0] asm_before;
        logic idle_ok;
        int idle;
        pat = 8'h3C;
        idle_ok = 1'b1;
        out_ready = 1'b1;
        sb.push_back(8'h3C);
        for (int i = 0; i < 8; i++) begin
            idle = int'($urandom_range(3, 0));
            for (int j = 0; j < idle; j++) begin
                in_valid = 1'b0;
                in = 1'($urandom);
                frame_start = 1'($urandom);
                ptr_before = dut.ptr;
                asm_before = dut.asm_word;
                @(posedge clk); #1;
                if (dut.ptr !== ptr_before || dut.asm_word !== asm_before || out_valid !== 1'b0) idle_ok = 1'b0;
            end
            send_bit(pat[i], i == 0);
        end
        total_cnt++; if (!idle_ok) $display("FAIL stall_idle: got state change on idle cycle expected none"); else pass_cnt++;
        total_cnt++; if (out_valid !== 1'b1 || out !== 8'h3C)
            $display("FAIL stall_word: got valid=%b out=%h expected valid=1 out=3c", out_valid, out); else pass_cnt++;
        total_cnt++; if (overrun !== 1'b0) $display("FAIL stall_overrun: got %b expected 0", overrun); else pass_cnt++;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_msb_first();
        test_back_pressure();
        test_resync();
        test_reset_hold();
        test_stall_gaps();
        repeat (2) @(posedge clk);
        #1;
        total_cnt++; if (sb.size() != 0) $display("FAIL sb_drained: got %0d pending expected 0", sb.size()); else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
